// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the femtoRV32 single-port-memory datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and traps illegal opcodes and memory stalls.
module multicycle_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_inst_op,
    input  logic             i_mem_ready,
    input  logic             i_branch_cond,
    output logic             o_mem_req,
    output logic             o_mem_re,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_src,
    output logic [1:0]       o_alu_a_sel,
    output logic             o_alu_src,
    output logic [1:0]       o_alu_op,
    output logic             o_reg_write,
    output logic [1:0]       o_wb_sel,
    output logic             o_halted,
    output logic             o_illegal_inst,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_instret,
    output logic [2:0]       o_state
);

    localparam int unsigned    ToW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] OpR      = 5'b01100;
    localparam logic [4:0] OpI      = 5'b00100;
    localparam logic [4:0] OpLd     = 5'b00000;
    localparam logic [4:0] OpSt     = 5'b01000;
    localparam logic [4:0] OpBr     = 5'b11000;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpFence  = 5'b00011;
    localparam logic [4:0] OpSystem = 5'b11100;
    localparam logic [4:0] OpCustom = 5'b10001;

    typedef enum logic [2:0] {
        StBoot   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ClsR     = 4'd0,
        ClsI     = 4'd1,
        ClsLd    = 4'd2,
        ClsSt    = 4'd3,
        ClsBr    = 4'd4,
        ClsJal   = 4'd5,
        ClsJalr  = 4'd6,
        ClsLui   = 4'd7,
        ClsAuipc = 4'd8
    } cls_e;

    state_e           r_state, w_state_d;
    cls_e             r_cls, w_cls_d;
    logic             r_illegal, w_illegal_d;
    logic             r_timeout, w_timeout_d;
    logic [ToW-1:0]   r_to_cnt, w_to_cnt_d;
    logic [CNT_W-1:0] r_instret, w_instret_d;
    logic             w_stall;
    logic             w_to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StBoot;
            r_cls     <= ClsR;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_to_cnt  <= '0;
            r_instret <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cls     <= w_cls_d;
            r_illegal <= w_illegal_d;
            r_timeout <= w_timeout_d;
            r_to_cnt  <= w_to_cnt_d;
            r_instret <= w_instret_d;
        end
    end

    // Counter is zero on every entry to FETCH/MEM because it only survives a stall-in-place.
    always_comb begin
        w_stall    = ((r_state == StFetch) || (r_state == StMem)) && !i_mem_ready;
        w_to_hit   = w_stall && (TIMEOUT_CYCLES != 0) && (r_to_cnt == ToLast);
        w_to_cnt_d = w_stall ? (r_to_cnt + ToW'(1)) : '0;
    end

    always_comb begin
        w_instret_d = r_instret;
        if ((w_state_d == StFetch) && (r_state != StFetch) && (r_state != StBoot)) begin
            w_instret_d = r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cls_d     = r_cls;
        w_illegal_d = r_illegal;
        w_timeout_d = r_timeout;
        o_mem_req   = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_addr_sel  = 1'b0;
        o_ir_write  = 1'b0;
        o_pc_write  = 1'b0;
        o_pc_src    = 2'b00;
        o_alu_a_sel = 2'b00;
        o_alu_src   = 1'b0;
        o_alu_op    = 2'b00;
        o_reg_write = 1'b0;
        o_wb_sel    = 2'b00;
        o_halted    = 1'b0;

        case (r_state)
            StBoot: w_state_d = StFetch;

            StFetch: begin
                o_mem_req = 1'b1;
                o_mem_re  = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_state_d  = StDecode;
                end else if (w_to_hit) begin
                    w_state_d   = StHalt;
                    w_timeout_d = 1'b1;
                end
            end

            StDecode: begin
                w_state_d = StExec;
                case (i_inst_op)
                    OpR:      w_cls_d = ClsR;
                    OpI:      w_cls_d = ClsI;
                    OpLd:     w_cls_d = ClsLd;
                    OpSt:     w_cls_d = ClsSt;
                    OpBr:     w_cls_d = ClsBr;
                    OpJal:    w_cls_d = ClsJal;
                    OpJalr:   w_cls_d = ClsJalr;
                    OpLui:    w_cls_d = ClsLui;
                    OpAuipc:  w_cls_d = ClsAuipc;
                    OpFence:  w_state_d = StFetch;
                    OpSystem: w_state_d = StHalt;
                    OpCustom: w_state_d = StHalt;
                    default: begin
                        w_state_d   = StHalt;
                        w_illegal_d = 1'b1;
                    end
                endcase
            end

            StExec: begin
                w_state_d = StWb;
                case (r_cls)
                    ClsR: o_alu_op = 2'b10;
                    ClsI: begin
                        o_alu_src = 1'b1;
                        o_alu_op  = 2'b11;
                    end
                    ClsLd, ClsSt: begin
                        o_alu_src = 1'b1;
                        w_state_d = StMem;
                    end
                    ClsBr: begin
                        o_alu_op   = 2'b01;
                        o_pc_write = i_branch_cond;
                        o_pc_src   = 2'b01;
                        w_state_d  = StFetch;
                    end
                    ClsJal: begin
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'b01;
                    end
                    ClsJalr: begin
                        o_alu_src  = 1'b1;
                        o_pc_write = 1'b1;
                        o_pc_src   = 2'b10;
                    end
                    ClsLui: begin
                        o_alu_a_sel = 2'b10;
                        o_alu_src   = 1'b1;
                    end
                    ClsAuipc: begin
                        o_alu_a_sel = 2'b01;
                        o_alu_src   = 1'b1;
                    end
                    default: w_state_d = StFetch;
                endcase
            end

            StMem: begin
                o_mem_req  = 1'b1;
                o_addr_sel = 1'b1;
                o_mem_re   = (r_cls == ClsLd);
                o_mem_we   = (r_cls == ClsSt);
                if (i_mem_ready) begin
                    w_state_d = (r_cls == ClsLd) ? StWb : StFetch;
                end else if (w_to_hit) begin
                    w_state_d   = StHalt;
                    w_timeout_d = 1'b1;
                end
            end

            StWb: begin
                o_reg_write = 1'b1;
                if (r_cls == ClsLd) begin
                    o_wb_sel = 2'b01;
                end else if ((r_cls == ClsJal) || (r_cls == ClsJalr)) begin
                    o_wb_sel = 2'b10;
                end
                w_state_d = StFetch;
            end

            StHalt: o_halted = 1'b1;

            default: w_state_d = StHalt;
        endcase
    end

    assign o_state        = r_state;
    assign o_illegal_inst = r_illegal;
    assign o_mem_timeout  = r_timeout;
    assign o_instret      = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed vector table, corner-case sequences and
// randomized traffic checked against an instruction-level plan model.
module tb_multicycle_ctrl_fsm;

    localparam int TO = 4;

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_ST    = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_FENCE = 5'b00011;
    localparam logic [4:0] OP_SYS   = 5'b11100;
    localparam logic [4:0] OP_CUST  = 5'b10001;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_re;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_a_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       halted;
        logic       illegal;
        logic       timeout;
    } ctrl_t;

    typedef struct {
        logic [4:0] op;
        logic       rdy;
        logic       bc;
        ctrl_t      exp;
        logic [7:0] ir;
    } vec_t;

    logic       clk, rst_n;
    logic [4:0] op;
    logic       rdy, bc;
    logic       mem_req, mem_re, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0] pc_src, alu_a_sel, alu_op, wb_sel;
    logic       alu_src, reg_write, halted, illegal_inst, mem_timeout;
    logic [7:0] instret;
    logic [2:0] state;
    ctrl_t      act;

    int n_cmp, n_bad;

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inst_op     (op),
        .i_mem_ready   (rdy),
        .i_branch_cond (bc),
        .o_mem_req     (mem_req),
        .o_mem_re      (mem_re),
        .o_mem_we      (mem_we),
        .o_addr_sel    (addr_sel),
        .o_ir_write    (ir_write),
        .o_pc_write    (pc_write),
        .o_pc_src      (pc_src),
        .o_alu_a_sel   (alu_a_sel),
        .o_alu_src     (alu_src),
        .o_alu_op      (alu_op),
        .o_reg_write   (reg_write),
        .o_wb_sel      (wb_sel),
        .o_halted      (halted),
        .o_illegal_inst(illegal_inst),
        .o_mem_timeout (mem_timeout),
        .o_instret     (instret),
        .o_state       (state)
    );

    assign act = {state, mem_req, mem_re, mem_we, addr_sel, ir_write, pc_write, pc_src,
                  alu_a_sel, alu_src, alu_op, reg_write, wb_sel, halted, illegal_inst,
                  mem_timeout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: an instruction expands into a plan of phases (3 EXEC, 4 MEM, 5 WB);
    // an exhausted plan retires the instruction and returns to fetch.
    int         m_phase;
    logic [4:0] m_op;
    int         m_plan[$];
    logic       m_ill, m_tmo;
    logic [7:0] m_ir;
    int         m_wait;
    logic [4:0] op_list [12];
    vec_t       tbl[$];

    task automatic model_reset();
        m_phase = 0;
        m_op    = 5'd0;
        m_plan.delete();
        m_ill   = 1'b0;
        m_tmo   = 1'b0;
        m_ir    = 8'd0;
        m_wait  = 0;
    endtask

    task automatic advance();
        m_wait = 0;
        if (m_plan.size() > 0) begin
            m_phase = m_plan.pop_front();
        end else begin
            m_phase = 1;
            m_ir    = m_ir + 8'd1;
        end
    endtask

    function automatic ctrl_t model_out(input logic r, input logic b);
        ctrl_t e;
        e         = '0;
        e.state   = 3'(m_phase);
        e.illegal = m_ill;
        e.timeout = m_tmo;
        case (m_phase)
            1: begin
                e.mem_req  = 1'b1;
                e.mem_re   = 1'b1;
                e.ir_write = r;
                e.pc_write = r;
            end
            3: case (m_op)
                OP_R: e.alu_op = 2'b10;
                OP_I: begin e.alu_src = 1'b1; e.alu_op = 2'b11; end
                OP_LD, OP_ST: e.alu_src = 1'b1;
                OP_BR: begin e.alu_op = 2'b01; e.pc_write = b; e.pc_src = 2'b01; end
                OP_JAL: begin e.pc_write = 1'b1; e.pc_src = 2'b01; end
                OP_JALR: begin e.alu_src = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10; end
                OP_LUI: begin e.alu_a_sel = 2'b10; e.alu_src = 1'b1; end
                OP_AUIPC: begin e.alu_a_sel = 2'b01; e.alu_src = 1'b1; end
                default: ;
            endcase
            4: begin
                e.mem_req  = 1'b1;
                e.addr_sel = 1'b1;
                e.mem_re   = (m_op == OP_LD);
                e.mem_we   = (m_op == OP_ST);
            end
            5: begin
                e.reg_write = 1'b1;
                if (m_op == OP_LD) e.wb_sel = 2'b01;
                else if (m_op == OP_JAL || m_op == OP_JALR) e.wb_sel = 2'b10;
            end
            6: e.halted = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_step(input logic r, input logic [4:0] o);
        case (m_phase)
            0: begin m_phase = 1; m_wait = 0; end
            1, 4: begin
                if (!r) begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_phase = 6;
                        m_tmo   = 1'b1;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                    m_wait  = 0;
                end else begin
                    advance();
                end
            end
            2: begin
                m_op = o;
                case (o)
                    OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
                        m_plan = '{3, 5};
                        advance();
                    end
                    OP_LD: begin m_plan = '{3, 4, 5}; advance(); end
                    OP_ST: begin m_plan = '{3, 4}; advance(); end
                    OP_BR: begin m_plan = '{3}; advance(); end
                    OP_FENCE: begin m_plan.delete(); advance(); end
                    OP_SYS, OP_CUST: m_phase = 6;
                    default: begin m_phase = 6; m_ill = 1'b1; end
                endcase
            end
            3, 5: advance();
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input ctrl_t e, input logic [7:0] ir);
        n_cmp++;
        if (act !== e || instret !== ir) begin
            n_bad++;
            $display("FAIL %s @%0t: got ctrl=%h instret=%0d, expected ctrl=%h instret=%0d",
                     name, $time, act, instret, e, ir);
        end
    endtask

    task automatic cyc(input string name, input logic [4:0] o, input logic r, input logic b,
                       input ctrl_t e, input logic [7:0] ir);
        op  = o;
        rdy = r;
        bc  = b;
        #1;
        chk(name, e, ir);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        op    = OP_R;
        rdy   = 1'b0;
        bc    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [4:0] o, input logic r, input logic b, input ctrl_t e,
                       input logic [7:0] ir);
        tbl.push_back('{o, r, b, e, ir});
    endtask

    function automatic logic [4:0] pick(input bit legal_only);
        if (legal_only) return op_list[$urandom_range(9)];
        if ($urandom_range(3) == 0) return 5'($urandom);
        return op_list[$urandom_range(11)];
    endfunction

    task automatic run_random(input int cycles, input bit legal_only);
        logic [4:0] o;
        logic       r, b;
        o = OP_R;
        for (int k = 0; k < cycles; k++) begin
            if (m_phase <= 1) o = pick(legal_only);
            if (legal_only) r = ($urandom_range(3) != 0) || (m_wait >= 2);
            else r = ($urandom_range(4) != 0);
            b   = 1'($urandom_range(1));
            op  = o;
            rdy = r;
            bc  = b;
            #1;
            chk("random", model_out(r, b), m_ir);
            if (m_phase == 6) begin
                apply_reset();
                model_reset();
            end else begin
                model_step(r, o);
                @(negedge clk);
            end
        end
    endtask

    ctrl_t c_zero, c_fetch, c_fwait, c_dec, c_ldm;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        op    = OP_R;
        rdy   = 1'b0;
        bc    = 1'b0;
        model_reset();
        op_list = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
                    OP_FENCE, OP_SYS, OP_CUST};

        c_zero  = '0;
        c_fetch = '{state: 3'd1, mem_req: 1'b1, mem_re: 1'b1, ir_write: 1'b1,
                    pc_write: 1'b1, default: '0};
        c_fwait = '{state: 3'd1, mem_req: 1'b1, mem_re: 1'b1, default: '0};
        c_dec   = '{state: 3'd2, default: '0};
        c_ldm   = '{state: 3'd4, mem_req: 1'b1, mem_re: 1'b1, addr_sel: 1'b1, default: '0};

        add(OP_R, 1, 0, c_zero, 8'd0);
        add(OP_R, 1, 0, c_fetch, 8'd0);
        add(OP_R, 1, 0, c_dec, 8'd0);
        add(OP_R, 1, 0, '{state: 3'd3, alu_op: 2'b10, default: '0}, 8'd0);
        add(OP_R, 1, 0, '{state: 3'd5, reg_write: 1'b1, default: '0}, 8'd0);
        add(OP_LD, 1, 0, c_fetch, 8'd1);
        add(OP_LD, 1, 0, c_dec, 8'd1);
        add(OP_LD, 0, 0, '{state: 3'd3, alu_src: 1'b1, default: '0}, 8'd1);
        add(OP_LD, 0, 0, c_ldm, 8'd1);
        add(OP_LD, 0, 0, c_ldm, 8'd1);
        add(OP_LD, 0, 0, c_ldm, 8'd1);
        add(OP_LD, 1, 0, c_ldm, 8'd1);
        add(OP_LD, 1, 0, '{state: 3'd5, reg_write: 1'b1, wb_sel: 2'b01, default: '0}, 8'd1);
        add(OP_BR, 1, 1, c_fetch, 8'd2);
        add(OP_BR, 1, 1, c_dec, 8'd2);
        add(OP_BR, 1, 1, '{state: 3'd3, alu_op: 2'b01, pc_write: 1'b1, pc_src: 2'b01,
                           default: '0}, 8'd2);
        add(OP_BR, 1, 0, c_fetch, 8'd3);
        add(OP_BR, 1, 0, c_dec, 8'd3);
        add(OP_BR, 1, 0, '{state: 3'd3, alu_op: 2'b01, pc_src: 2'b01, default: '0}, 8'd3);
        add(OP_ST, 1, 0, c_fetch, 8'd4);
        add(OP_ST, 1, 0, c_dec, 8'd4);
        add(OP_ST, 1, 0, '{state: 3'd3, alu_src: 1'b1, default: '0}, 8'd4);
        add(OP_ST, 1, 0, '{state: 3'd4, mem_req: 1'b1, mem_we: 1'b1, addr_sel: 1'b1,
                           default: '0}, 8'd4);
        add(OP_JAL, 1, 0, c_fetch, 8'd5);
        add(OP_JAL, 1, 0, c_dec, 8'd5);
        add(OP_JAL, 1, 0, '{state: 3'd3, pc_write: 1'b1, pc_src: 2'b01, default: '0}, 8'd5);
        add(OP_JAL, 1, 0, '{state: 3'd5, reg_write: 1'b1, wb_sel: 2'b10, default: '0}, 8'd5);
        add(OP_JALR, 1, 0, c_fetch, 8'd6);
        add(OP_JALR, 1, 0, c_dec, 8'd6);
        add(OP_JALR, 1, 0, '{state: 3'd3, alu_src: 1'b1, pc_write: 1'b1, pc_src: 2'b10,
                             default: '0}, 8'd6);
        add(OP_JALR, 1, 0, '{state: 3'd5, reg_write: 1'b1, wb_sel: 2'b10, default: '0}, 8'd6);
        add(OP_LUI, 1, 0, c_fetch, 8'd7);
        add(OP_LUI, 1, 0, c_dec, 8'd7);
        add(OP_LUI, 1, 0, '{state: 3'd3, alu_a_sel: 2'b10, alu_src: 1'b1, default: '0}, 8'd7);
        add(OP_LUI, 1, 0, '{state: 3'd5, reg_write: 1'b1, default: '0}, 8'd7);
        add(OP_FENCE, 1, 0, c_fetch, 8'd8);
        add(OP_FENCE, 1, 0, c_dec, 8'd8);
        add(OP_SYS, 1, 0, c_fetch, 8'd9);
        add(OP_SYS, 1, 0, c_dec, 8'd9);
        add(OP_SYS, 1, 0, '{state: 3'd6, halted: 1'b1, default: '0}, 8'd9);
        add(OP_SYS, 1, 0, '{state: 3'd6, halted: 1'b1, default: '0}, 8'd9);

        // Reset held for three clocks, outputs quiet throughout.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_hold", c_zero, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].bc, tbl[i].exp,
                tbl[i].ir);
        end

        // FETCH starved for TO cycles -> timeout halt.
        apply_reset();
        cyc("to_boot", OP_R, 0, 0, c_zero, 8'd0);
        for (int i = 0; i < TO; i++) cyc($sformatf("to_wait%0d", i), OP_R, 0, 0, c_fwait, 8'd0);
        cyc("to_halt", OP_R, 0, 0, '{state: 3'd6, halted: 1'b1, timeout: 1'b1, default: '0},
            8'd0);

        // Ready arrives on the last allowed cycle: no fault.
        apply_reset();
        cyc("late_boot", OP_R, 0, 0, c_zero, 8'd0);
        for (int i = 0; i < TO - 1; i++) cyc($sformatf("late_wait%0d", i), OP_R, 0, 0, c_fwait,
                                             8'd0);
        cyc("late_ready", OP_R, 1, 0, c_fetch, 8'd0);
        cyc("late_decode", OP_R, 1, 0, c_dec, 8'd0);

        // Illegal opcode.
        apply_reset();
        cyc("ill_boot", 5'b11111, 1, 0, c_zero, 8'd0);
        cyc("ill_fetch", 5'b11111, 1, 0, c_fetch, 8'd0);
        cyc("ill_decode", 5'b11111, 1, 0, c_dec, 8'd0);
        cyc("ill_halt", 5'b11111, 1, 0, '{state: 3'd6, halted: 1'b1, illegal: 1'b1,
                                          default: '0}, 8'd0);
        cyc("ill_hold", OP_R, 1, 0, '{state: 3'd6, halted: 1'b1, illegal: 1'b1,
                                      default: '0}, 8'd0);

        // Asynchronous reset in the middle of a stalled load.
        apply_reset();
        cyc("ar_boot", OP_R, 1, 0, c_zero, 8'd0);
        cyc("ar_fetch", OP_R, 1, 0, c_fetch, 8'd0);
        cyc("ar_dec", OP_R, 1, 0, c_dec, 8'd0);
        cyc("ar_exec", OP_R, 1, 0, '{state: 3'd3, alu_op: 2'b10, default: '0}, 8'd0);
        cyc("ar_wb", OP_R, 1, 0, '{state: 3'd5, reg_write: 1'b1, default: '0}, 8'd0);
        cyc("ar_fetch2", OP_LD, 1, 0, c_fetch, 8'd1);
        cyc("ar_dec2", OP_LD, 1, 0, c_dec, 8'd1);
        cyc("ar_exec2", OP_LD, 0, 0, '{state: 3'd3, alu_src: 1'b1, default: '0}, 8'd1);
        cyc("ar_mem", OP_LD, 0, 0, c_ldm, 8'd1);
        #1;
        chk("ar_mem_held", c_ldm, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_drop", c_zero, 8'd0);

        apply_reset();
        model_reset();
        run_random(2400, 1'b1);
        run_random(1500, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
